// File: rtl/mem_io_responder.sv
// Memory/IO responder for the multicycle processor bus: word RAM plus
// memory-mapped LED, HEX, switch, button-status and cycle-counter registers.
// Every edge accepts one request; read data appears one cycle later.
module mem_io_responder #(
    parameter int unsigned RAM_AW          = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [15:0] Address,
    input  logic [15:0] WriteData,
    input  logic        Write,
    output logic [15:0] ReadData,
    input  logic [15:0] SW_in,
    input  logic        Btn_in,
    output logic [15:0] LED_out,
    output logic [15:0] HEX_out,
    output logic        AddrError
);

    localparam int unsigned DW        = 16;
    localparam int unsigned RAM_WORDS = 2 ** RAM_AW;
    localparam int unsigned DBW       = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [3:0] SEL_RAM  = 4'h0;
    localparam logic [3:0] SEL_LED  = 4'h1;
    localparam logic [3:0] SEL_HEX  = 4'h2;
    localparam logic [3:0] SEL_SW   = 4'h3;
    localparam logic [3:0] SEL_STAT = 4'h4;
    localparam logic [3:0] SEL_CNT  = 4'h5;

    // Storage and registers
    logic [DW-1:0]     mem_q [RAM_WORDS];
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [DW-1:0]     led_q, led_d;
    logic [DW-1:0]     hex_q, hex_d;
    logic              aerr_q, aerr_d;
    logic [DW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]     sw_s1_q, sw_s2_q;
    logic              btn_s1_q, btn_s2_q;
    logic              btn_stable_q, btn_stable_d;
    logic [DBW-1:0]    deb_q, deb_d;
    logic              flag_q, flag_d;

    logic [3:0]        sel_c;
    logic [RAM_AW-1:0] widx_c;
    logic              ram_we_c;
    logic              press_c;
    logic              unused_addr_c;

    assign sel_c         = Address[15:12];
    assign widx_c        = Address[RAM_AW-1:0];
    // Upper RAM offset bits alias onto the same word
    assign unused_addr_c = ^Address[11:RAM_AW];
    // RAM is not reset, so gate writes explicitly while reset is held
    assign ram_we_c      = Write && Resetn && (sel_c == SEL_RAM);

    // RAM write port (contents are not reset)
    always_ff @(posedge Clock) begin
        if (ram_we_c) begin
            mem_q[widx_c] <= WriteData;
        end
    end

    // Next-state: read mux, register writes, debounce, flag, counter
    always_comb begin
        rdata_d      = '0;
        led_d        = led_q;
        hex_d        = hex_q;
        aerr_d       = 1'b0;
        cnt_d        = cnt_q + DW'(1);
        btn_stable_d = btn_stable_q;
        deb_d        = '0;
        press_c      = 1'b0;
        flag_d       = flag_q;

        // Read returns pre-edge contents, regardless of Write
        case (sel_c)
            SEL_RAM:  rdata_d = mem_q[widx_c];
            SEL_LED:  rdata_d = led_q;
            SEL_HEX:  rdata_d = hex_q;
            SEL_SW:   rdata_d = sw_s2_q;
            SEL_STAT: rdata_d = {15'h0000, flag_q};
            SEL_CNT:  rdata_d = cnt_q;
            default: begin
                rdata_d = '0;
                aerr_d  = 1'b1;
            end
        endcase

        if (Write) begin
            case (sel_c)
                SEL_LED: led_d = WriteData;
                SEL_HEX: hex_d = WriteData;
                SEL_CNT: cnt_d = WriteData;
                default: ;
            endcase
        end

        // Stable state changes only after a full run of differing edges
        if (btn_s2_q != btn_stable_q) begin
            if (deb_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
                btn_stable_d = btn_s2_q;
                deb_d        = '0;
                press_c      = ~btn_s2_q;
            end else begin
                deb_d = deb_q + DBW'(1);
            end
        end

        // A press on the same edge as a clearing read keeps the flag set
        if (press_c) begin
            flag_d = 1'b1;
        end else if (!Write && (sel_c == SEL_STAT)) begin
            flag_d = 1'b0;
        end
    end

    // Register update with asynchronous reset
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            rdata_q      <= '0;
            led_q        <= '0;
            hex_q        <= '0;
            aerr_q       <= 1'b0;
            cnt_q        <= '0;
            sw_s1_q      <= '0;
            sw_s2_q      <= '0;
            btn_s1_q     <= 1'b1;
            btn_s2_q     <= 1'b1;
            btn_stable_q <= 1'b1;
            deb_q        <= '0;
            flag_q       <= 1'b0;
        end else begin
            rdata_q      <= rdata_d;
            led_q        <= led_d;
            hex_q        <= hex_d;
            aerr_q       <= aerr_d;
            cnt_q        <= cnt_d;
            sw_s1_q      <= SW_in;
            sw_s2_q      <= sw_s1_q;
            btn_s1_q     <= Btn_in;
            btn_s2_q     <= btn_s1_q;
            btn_stable_q <= btn_stable_d;
            deb_q        <= deb_d;
            flag_q       <= flag_d;
        end
    end

    assign ReadData  = rdata_q;
    assign LED_out   = led_q;
    assign HEX_out   = hex_q;
    assign AddrError = aerr_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder with DEBOUNCE_CYCLES=4.
module tb_mem_io_responder;

    logic        Clock;
    logic        Resetn;
    logic [15:0] Address;
    logic [15:0] WriteData;
    logic        Write;
    logic [15:0] ReadData;
    logic [15:0] SW_in;
    logic        Btn_in;
    logic [15:0] LED_out;
    logic [15:0] HEX_out;
    logic        AddrError;

    int n_cmp;
    int n_err;

    mem_io_responder #(
        .RAM_AW         (5),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Address  (Address),
        .WriteData(WriteData),
        .Write    (Write),
        .ReadData (ReadData),
        .SW_in    (SW_in),
        .Btn_in   (Btn_in),
        .LED_out  (LED_out),
        .HEX_out  (HEX_out),
        .AddrError(AddrError)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one rising edge, then settle 1 time unit past it
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [15:0] a, input logic w, input logic [15:0] d);
        Address   = a;
        Write     = w;
        WriteData = d;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        Resetn    = 1'b0;
        Address   = 16'h0000;
        WriteData = 16'h0000;
        Write     = 1'b0;
        SW_in     = 16'h0000;
        Btn_in    = 1'b1;

        #3;
        chk("rst_rdata", ReadData, 16'h0000);
        chk("rst_led",   LED_out,  16'h0000);
        chk("rst_hex",   HEX_out,  16'h0000);
        chk("rst_aerr",  {15'h0, AddrError}, 16'h0000);
        tick();
        tick();
        Resetn = 1'b1;

        // RAM with aliasing and read-during-write
        req(16'h0003, 1'b1, 16'hA5A5); tick();
        req(16'h0023, 1'b1, 16'h1234); tick();
        req(16'h0003, 1'b0, 16'h0000); tick();
        chk("ram_alias", ReadData, 16'h1234);
        req(16'h0003, 1'b1, 16'h5555); tick();
        chk("ram_rdw_old", ReadData, 16'h1234);
        req(16'h0003, 1'b0, 16'h0000); tick();
        chk("ram_rdw_new", ReadData, 16'h5555);

        // LED / HEX registers
        req(16'h1000, 1'b1, 16'hBEEF); tick();
        chk("led_wr", LED_out, 16'hBEEF);
        req(16'h2000, 1'b1, 16'h0042); tick();
        chk("hex_wr", HEX_out, 16'h0042);
        req(16'h1000, 1'b0, 16'h0000); tick();
        chk("led_rd", ReadData, 16'hBEEF);

        // Unmapped read and write
        req(16'h7000, 1'b0, 16'h0000); tick();
        chk("unmap_rd_data", ReadData, 16'h0000);
        chk("unmap_rd_err", {15'h0, AddrError}, 16'h0001);
        req(16'h0003, 1'b0, 16'h0000); tick();
        chk("unmap_err_pulse", {15'h0, AddrError}, 16'h0000);
        req(16'hF123, 1'b1, 16'hFFFF); tick();
        chk("unmap_wr_err", {15'h0, AddrError}, 16'h0001);
        chk("unmap_wr_led", LED_out, 16'hBEEF);
        chk("unmap_wr_hex", HEX_out, 16'h0042);

        // Write to switches is ignored, no error
        req(16'h3000, 1'b1, 16'h1111); tick();
        chk("sw_wr_err", {15'h0, AddrError}, 16'h0000);
        chk("sw_wr_rd", ReadData, 16'h0000);
        req(16'h3000, 1'b0, 16'h0000); tick();
        chk("sw_after_wr", ReadData, 16'h0000);

        // Switch synchronizer latency
        SW_in = 16'h00F0;
        tick();
        chk("sw_k", ReadData, 16'h0000);
        tick();
        chk("sw_k1", ReadData, 16'h0000);
        tick();
        chk("sw_k2", ReadData, 16'h00F0);

        // 3-cycle glitch must not register
        Btn_in = 1'b0;
        tick(); tick(); tick();
        Btn_in = 1'b1;
        repeat (6) tick();
        req(16'h4000, 1'b0, 16'h0000); tick();
        chk("glitch_flag", ReadData, 16'h0000);

        // Held press: flag set after edge 6, read clears it
        req(16'h3000, 1'b0, 16'h0000);
        Btn_in = 1'b0;
        repeat (6) tick();
        req(16'h4000, 1'b0, 16'h0000); tick();
        chk("press_flag", ReadData, 16'h0001);
        tick();
        chk("flag_cleared", ReadData, 16'h0000);

        // Release (sets nothing), then press landing on a clearing read
        req(16'h3000, 1'b0, 16'h0000);
        Btn_in = 1'b1;
        repeat (8) tick();
        req(16'h4000, 1'b0, 16'h0000); tick();
        chk("release_noflag", ReadData, 16'h0000);
        req(16'h3000, 1'b0, 16'h0000);
        Btn_in = 1'b0;
        repeat (5) tick();
        req(16'h4000, 1'b0, 16'h0000); tick();
        chk("collide_pre", ReadData, 16'h0000);
        // Status write neither clears the flag nor errors
        req(16'h4000, 1'b1, 16'h0000); tick();
        chk("collide_kept", ReadData, 16'h0001);
        chk("stat_wr_err", {15'h0, AddrError}, 16'h0000);
        req(16'h3000, 1'b0, 16'h0000);
        Btn_in = 1'b1;

        // Counter load and wrap
        req(16'h5000, 1'b1, 16'hFFFE); tick();
        req(16'h5000, 1'b0, 16'h0000); tick();
        chk("cnt_n1", ReadData, 16'hFFFE);
        tick();
        chk("cnt_n2", ReadData, 16'hFFFF);
        tick();
        chk("cnt_n3", ReadData, 16'h0000);
        tick();
        chk("cnt_n4", ReadData, 16'h0001);

        // Asynchronous reset during a LED write
        req(16'h1000, 1'b1, 16'hCAFE);
        #2;
        Resetn = 1'b0;
        #1;
        chk("arst_led", LED_out, 16'h0000);
        chk("arst_hex", HEX_out, 16'h0000);
        chk("arst_rdata", ReadData, 16'h0000);
        tick();
        chk("arst_nowrite", LED_out, 16'h0000);
        #2;
        Resetn = 1'b1;
        req(16'h5000, 1'b0, 16'h0000); tick();
        chk("arst_cnt", ReadData, 16'h0000);
        req(16'h4000, 1'b0, 16'h0000); tick();
        chk("arst_flag", ReadData, 16'h0000);
        req(16'h1000, 1'b0, 16'h0000); tick();
        chk("arst_led_rd", ReadData, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
